// File: rtl/tensor_ram_writer_pkg.sv
// tensor_ram_writer_pkg: shared sizes, word/lane types and FSM states for the tensor RAM writer
package tensor_ram_writer_pkg;
    localparam int IMG_W      = 32;
    localparam int IMG_H      = 32;
    localparam int MAX_NUM_CH = 64;
    localparam int LANES      = 16;
    localparam int DEPTH      = IMG_W * IMG_H * (MAX_NUM_CH / LANES);
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int OW_W       = $clog2(IMG_W + 1);
    localparam int OH_W       = $clog2(IMG_H + 1);
    localparam int CH_W       = $clog2(MAX_NUM_CH);
    localparam int ROW_W      = $clog2(IMG_H);
    localparam int COL_W      = $clog2(IMG_W);
    localparam int LANE_W     = $clog2(LANES);
    localparam int GRP_W      = CH_W - LANE_W;
    localparam int PLANE_W    = OW_W + OH_W;

    typedef logic [7:0]          int8_t;
    typedef logic [8*LANES-1:0]  tensor_word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [LANE_W-1:0]   lane_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    // Replace one int8 lane of a RAM word.
    function automatic tensor_word_t put_lane(tensor_word_t w, lane_t l, int8_t d);
        tensor_word_t r;
        r = w;
        r[8*l +: 8] = d;
        return r;
    endfunction
endpackage

// File: rtl/tensor_ram_writer_if.sv
// tensor_ram_writer_if: result beat stream plus destination RAM read/write port
interface tensor_ram_writer_if;
    import tensor_ram_writer_pkg::*;
    logic                        in_valid;
    logic                        in_ready;
    int8_t                       in_data;
    logic [ROW_W-1:0]            in_row;
    logic [COL_W-1:0]            in_col;
    addr_t                       rd_addr;
    tensor_word_t                rd_data;
    logic                        wr_we;
    addr_t                       wr_addr;
    tensor_word_t                wr_din;

    modport master (
        output in_valid, in_data, in_row, in_col, rd_data,
        input  in_ready, rd_addr, wr_we, wr_addr, wr_din
    );
    modport slave (
        input  in_valid, in_data, in_row, in_col, rd_data,
        output in_ready, rd_addr, wr_we, wr_addr, wr_din
    );
endinterface

// File: rtl/tensor_ram_writer_addr_gen.sv
// tensor_ram_writer_addr_gen: registers address, lane and data of an accepted beat into stage 1
module tensor_ram_writer_addr_gen
    import tensor_ram_writer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GRP_W-1:0] grp,
    input  lane_t            lane,
    input  logic [OW_W-1:0]  out_w,
    input  logic [OH_W-1:0]  out_h,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  int8_t            data,
    output logic             s1_valid,
    output addr_t            s1_addr,
    output lane_t            s1_lane,
    output int8_t            s1_data
);
    addr_t addr;

    assign addr = ADDR_W'(grp) * ADDR_W'(out_w) * ADDR_W'(out_h)
                + ADDR_W'(row) * ADDR_W'(out_w) + ADDR_W'(col);

    // Stage 1 register: captured only for in-range beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_lane  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= load;
            if (load) begin
                s1_addr <= addr;
                s1_lane <= lane;
                s1_data <= data;
            end
        end
    end
endmodule

// File: rtl/tensor_ram_writer.sv
// tensor_ram_writer: packs int8 channel results into 16-lane RAM words via a forwarding RMW pipeline
module tensor_ram_writer
    import tensor_ram_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OW_W-1:0]     out_w,
    input  logic [OH_W-1:0]     out_h,
    input  logic [CH_W-1:0]     chnnl_idx,
    tensor_ram_writer_if.slave  bus,
    output logic                chan_done,
    output logic                err_oob
);
    state_t             state, state_nxt;
    logic [OW_W-1:0]    out_w_r;
    logic [OH_W-1:0]    out_h_r;
    logic [CH_W-1:0]    ch_r;
    logic [PLANE_W-1:0] cnt, cnt_nxt, plane;
    logic               accept, oob, good;
    logic               s1_valid, s2_valid, fwd_sel;
    addr_t              s1_addr, s2_addr;
    lane_t              s1_lane, s2_lane;
    int8_t              s1_data, s2_data;
    tensor_word_t       fwd_word, base, merged;

    assign bus.in_ready = state == ACTIVE;
    assign accept       = bus.in_valid && bus.in_ready;
    assign oob          = OH_W'(bus.in_row) >= out_h_r || OW_W'(bus.in_col) >= out_w_r;
    assign good         = accept && !oob;
    assign plane        = PLANE_W'(out_w_r) * PLANE_W'(out_h_r);
    assign cnt_nxt      = cnt + PLANE_W'(good);

    tensor_ram_writer_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (good),
        .grp      (ch_r[CH_W-1:LANE_W]),
        .lane     (ch_r[LANE_W-1:0]),
        .out_w    (out_w_r),
        .out_h    (out_h_r),
        .row      (bus.in_row),
        .col      (bus.in_col),
        .data     (bus.in_data),
        .s1_valid (s1_valid),
        .s1_addr  (s1_addr),
        .s1_lane  (s1_lane),
        .s1_data  (s1_data)
    );

    // Lane 0 starts a fresh word so stale data from the previous layer is cleared.
    assign base   = s2_lane == '0 ? '0 : fwd_sel ? fwd_word : bus.rd_data;
    assign merged = put_lane(base, s2_lane, s2_data);

    assign bus.rd_addr = s1_addr;
    assign bus.wr_we   = s2_valid;
    assign bus.wr_addr = s2_addr;
    assign bus.wr_din  = s2_valid ? merged : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; chan_done fires once both pipeline stages are empty.
    always_comb begin
        state_nxt = state;
        chan_done = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ACTIVE;
            ACTIVE:  if (cnt_nxt == plane) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) begin
                chan_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Layer config latch, beat counter and sticky out-of-range flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_w_r <= '0;
            out_h_r <= '0;
            ch_r    <= '0;
            cnt     <= '0;
            err_oob <= 1'b0;
        end else if (state == IDLE && start) begin
            out_w_r <= out_w;
            out_h_r <= out_h;
            ch_r    <= chnnl_idx;
            cnt     <= '0;
            err_oob <= 1'b0;
        end else if (state == ACTIVE) begin
            cnt     <= cnt_nxt;
            err_oob <= err_oob || (accept && oob);
        end
    end

    // Stage 2 register; a same-address write in flight is forwarded because the RAM read misses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_lane  <= '0;
            s2_data  <= '0;
            fwd_sel  <= 1'b0;
            fwd_word <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_lane  <= s1_lane;
            s2_data  <= s1_data;
            fwd_sel  <= s1_valid && s2_valid && s1_addr == s2_addr;
            fwd_word <= merged;
        end
    end
endmodule

// File: tb/tb_tensor_ram_writer.sv
// tb_tensor_ram_writer: directed scoreboard bench for tensor_ram_writer
module tb_tensor_ram_writer;
    import tensor_ram_writer_pkg::*;

    typedef struct {
        addr_t        a;
        tensor_word_t d;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [OW_W-1:0] out_w = '0;
    logic [OH_W-1:0] out_h = '0;
    logic [CH_W-1:0] chnnl_idx = '0;
    logic            chan_done, err_oob;

    tensor_word_t ram [DEPTH];
    tensor_word_t model [DEPTH];
    wr_t          q [$];
    wr_t          e;
    int           errors = 0;
    int           checks = 0;
    int           cur_w, cur_h, cur_ch;

    tensor_ram_writer_if bus ();

    tensor_ram_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .out_w     (out_w),
        .out_h     (out_h),
        .chnnl_idx (chnnl_idx),
        .bus       (bus.slave),
        .chan_done (chan_done),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    // Destination RAM: synchronous read returning the pre-write contents.
    always @(posedge clk) begin
        bus.rd_data <= ram[bus.rd_addr];
        if (bus.wr_we) ram[bus.wr_addr] <= bus.wr_din;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write is matched in order against the scoreboard.
    always @(negedge clk) begin
        if (bus.wr_we) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 128'(bus.wr_addr), 128'hFFFF);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 128'(bus.wr_addr), 128'(e.a));
                chk("wr_din", bus.wr_din, e.d);
            end
        end
    end

    task automatic do_start(input int w, input int h, input int ch);
        cur_w = w; cur_h = h; cur_ch = ch;
        out_w = OW_W'(w); out_h = OH_W'(h); chnnl_idx = CH_W'(ch);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input int d, input int r, input int c, input bit exp_wr);
        int           a;
        int           ln;
        tensor_word_t w;
        bus.in_valid = 1'b1;
        bus.in_data  = int8_t'(d);
        bus.in_row   = ROW_W'(r);
        bus.in_col   = COL_W'(c);
        chk("in_ready", 128'(bus.in_ready), 128'd1);
        if (exp_wr) begin
            a  = (cur_ch / 16) * cur_w * cur_h + r * cur_w + c;
            ln = cur_ch % 16;
            w  = (ln == 0) ? '0 : model[a];
            w[8*ln +: 8] = d[7:0];
            model[a] = w;
            q.push_back('{addr_t'(a), w});
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!chan_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("chan_done_latency", 128'(n), 128'd2);
        @(posedge clk); #1;
        chk("chan_done_pulse", 128'(chan_done), 128'd0);
        chk("idle_ready", 128'(bus.in_ready), 128'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("rst_wr_we", 128'(bus.wr_we), 128'd0);
        chk("rst_chan_done", 128'(chan_done), 128'd0);
        chk("rst_err_oob", 128'(err_oob), 128'd0);
        chk("rst_rd_addr", 128'(bus.rd_addr), 128'd0);
        chk("rst_wr_addr", 128'(bus.wr_addr), 128'd0);
        chk("rst_wr_din", bus.wr_din, 128'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = {LANES{8'hAA}};
            model[i] = {LANES{8'hAA}};
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_row   = '0;
        bus.in_col   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_reset_outputs();

        // Lane-0 plane: fresh words, stale 0xAA lanes cleared.
        do_start(2, 2, 0);
        beat(8'h11, 0, 0, 1);
        beat(8'h12, 0, 1, 1);
        beat(8'h13, 1, 0, 1);
        beat(8'h14, 1, 1, 1);
        wait_done();

        // RMW into lane 5 with out-of-range beats interleaved.
        do_start(2, 2, 5);
        chk("oob_cleared_start", 128'(err_oob), 128'd0);
        beat(8'h0A, 0, 0, 1);
        beat(8'h55, 2, 0, 0);
        chk("oob_row", 128'(err_oob), 128'd1);
        beat(8'h56, 0, 2, 0);
        beat(8'h5B, 0, 1, 1);
        beat(8'h5C, 1, 0, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_early_done", 128'(chan_done), 128'd0);
        end
        chk("still_active", 128'(bus.in_ready), 128'd1);
        beat(8'h5D, 1, 1, 1);
        wait_done();
        chk("oob_sticky", 128'(err_oob), 128'd1);

        // Second channel group: chnnl_idx 17 -> lane 1, base address 4.
        do_start(2, 2, 17);
        chk("oob_cleared_restart", 128'(err_oob), 128'd0);
        beat(8'h7F, 1, 1, 1);
        beat(8'h61, 0, 0, 1);
        beat(8'h62, 0, 1, 1);
        beat(8'h63, 1, 0, 1);
        wait_done();

        // Back-to-back same-address beats exercise forwarding.
        do_start(2, 2, 3);
        beat(8'h22, 0, 1, 1);
        beat(8'h33, 0, 1, 1);
        beat(8'h44, 0, 0, 1);
        beat(8'h45, 1, 0, 1);
        wait_done();

        // Reset while a beat sits in stage 1: it must never be written.
        do_start(2, 2, 0);
        beat(8'h99, 0, 0, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_flush_we", 128'(bus.wr_we), 128'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        chk_reset_outputs();
        repeat (4) @(posedge clk);
        #1;
        chk("addr0_intact", ram[0], model[0]);
        chk("addr1_fwd", ram[1], model[1]);
        chk("addr7_group", ram[7], model[7]);
        chk("sb_empty", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
